// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit (sense chosen by PARITY_ODD).
module uart_tx #(
   parameter logic [7:0] CLKS_PER_BIT = 8'd200,
   parameter logic       PARITY_ODD   = 1'b0
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Tx_DV,
   input  logic [7:0] i_Tx_Byte,
   output logic       o_Tx_Active,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Done
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_PARITY  = 3'd3,
      S_STOP    = 3'd4,
      S_CLEANUP = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_STOP    = 3'd4,
      S_CLEANUP = 3'd5
   } state_t;
`endif

   localparam logic [7:0] LAST_CNT = CLKS_PER_BIT - 8'd1;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] data_q, data_d;
   logic       serial_q, serial_d;
   logic       active_q, active_d;
   logic       done_q, done_d;
   logic       bit_end;

   assign bit_end = (cnt_q == LAST_CNT);

`ifndef UART_TX_PARITY_EN
   // PARITY_ODD has no effect in the 8N1 build.
   logic unused_parity_odd;
   assign unused_parity_odd = PARITY_ODD;
`endif

   // NOTE: sequential state uses non-blocking assignments only; reset is async assert.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         idx_q    <= 3'd0;
         data_q   <= 8'd0;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         serial_q <= serial_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      data_d   = data_q;
      serial_d = serial_q;
      active_d = active_q;
      done_d   = done_q;

      // Outputs are computed one cycle ahead so each bit lands on the line registered.
      case (state_q)
         S_IDLE: begin
            serial_d = 1'b1;
            done_d   = 1'b0;
            active_d = 1'b0;
            cnt_d    = 8'd0;
            idx_d    = 3'd0;
            if (i_Tx_DV) begin
               data_d   = i_Tx_Byte;
               serial_d = 1'b0;
               active_d = 1'b1;
               state_d  = S_START;
            end
         end

         S_START: begin
            serial_d = 1'b0;
            if (bit_end) begin
               cnt_d    = 8'd0;
               idx_d    = 3'd0;
               serial_d = data_q[0];
               state_d  = S_DATA;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_DATA: begin
            serial_d = data_q[idx_q];
            if (bit_end) begin
               cnt_d = 8'd0;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  serial_d = (^data_q) ^ PARITY_ODD;
                  state_d  = S_PARITY;
`else
                  serial_d = 1'b1;
                  state_d  = S_STOP;
`endif
               end else begin
                  idx_d    = idx_q + 3'd1;
                  serial_d = data_q[idx_q + 3'd1];
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               cnt_d    = 8'd0;
               serial_d = 1'b1;
               state_d  = S_STOP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
`endif

         S_STOP: begin
            serial_d = 1'b1;
            if (bit_end) begin
               cnt_d    = 8'd0;
               done_d   = 1'b1;
               active_d = 1'b0;
               state_d  = S_CLEANUP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_CLEANUP: begin
            serial_d = 1'b1;
            done_d   = 1'b0;
            state_d  = S_IDLE;
         end

         default: begin
            state_d  = S_IDLE;
            cnt_d    = 8'd0;
            idx_d    = 3'd0;
            serial_d = 1'b1;
            active_d = 1'b0;
            done_d   = 1'b0;
         end
      endcase
   end

   assign o_Tx_Serial = serial_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Done   = done_q;

endmodule
